piano_key_tracker: RTL

- Sits between the PS/2 byte receiver and the tone generator.
- Parses PS/2 set-2 make, break (F0) and extended (E0) sequences, and maps each key to a piano note 1..12 with the team's standard keycode-to-note mapper, instantiated internally with default layout.
- Tracks which notes are held and handles octave-shift keys.
- Outputs one active note under last-pressed priority, plus note-on/note-off strobes for the synthesis path.

---
 rtl/piano_key_tracker.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/piano_key_tracker.sv
// PS/2 set-2 keyboard front end for the tone generator: parses make/break/extended
// sequences, tracks held piano notes and octave, and emits last-pressed note with strobes.

// Default keyboard layout: bottom two letter rows form one chromatic octave (Z = C .. M = B).
module piano_note_map (
    input  logic [7:0] code,
    output logic [3:0] note
);

    // Scan code to note lookup; 0 means the key is not a note key.
    always_comb begin
        case (code)
            8'h1A:   note = 4'd1;
            8'h1B:   note = 4'd2;
            8'h22:   note = 4'd3;
            8'h23:   note = 4'd4;
            8'h21:   note = 4'd5;
            8'h2A:   note = 4'd6;
            8'h34:   note = 4'd7;
            8'h32:   note = 4'd8;
            8'h33:   note = 4'd9;
            8'h31:   note = 4'd10;
            8'h3B:   note = 4'd11;
            8'h3A:   note = 4'd12;
            default: note = 4'd0;
        endcase
    end

endmodule

module piano_key_tracker #(
    parameter logic [7:0] OCT_UP    = 8'h55,
    parameter logic [7:0] OCT_DOWN  = 8'h4E,
    parameter logic [2:0] OCT_RESET = 3'd4,
    parameter logic [2:0] OCT_MAX   = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    output logic [3:0]  note,
    output logic [2:0]  octave,
    output logic        note_valid,
    output logic        note_on,
    output logic        note_off,
    output logic [11:0] held_mask
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } pstate_t;

    pstate_t     state_r, state_s;
    logic [3:0]  key_note_s;
    logic [11:0] key_bit_s;
    logic [11:0] remain_s;
    logic [3:0]  note_r, note_s;
    logic [2:0]  octave_r, octave_s;
    logic [11:0] held_r, held_s;
    logic        note_valid_r;
    logic        note_on_r, note_on_s;
    logic        note_off_r, note_off_s;

    function automatic logic [3:0] highest_held(input logic [11:0] mask);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (mask[i]) begin
                res = 4'(i + 1);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    piano_note_map u_map (
        .code (scan_code),
        .note (key_note_s)
    );

    // One-hot position of the decoded note and the mask with that note removed.
    always_comb begin
        if (key_note_s != 4'd0) begin
            key_bit_s = 12'h001 << (key_note_s - 4'd1);
        end else begin
            key_bit_s = 12'h000;
        end
        remain_s = held_r & ~key_bit_s;
    end

    // Parser next state and the held/note/octave update for the accepted byte.
    // note_r doubles as the last-pressed register: it only ever holds the most recent make
    // or the fallback chosen after that note was released.
    always_comb begin
        state_s    = state_r;
        note_s     = note_r;
        octave_s   = octave_r;
        held_s     = held_r;
        note_on_s  = 1'b0;
        note_off_s = 1'b0;
        if (scan_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (scan_code == 8'hF0) begin
                        state_s = ST_BRK;
                    end else if (scan_code == 8'hE0) begin
                        state_s = ST_EXT;
                    end else begin
                        state_s = ST_IDLE;
                        if (key_note_s != 4'd0) begin
                            if ((held_r & key_bit_s) == 12'h000) begin
                                held_s    = held_r | key_bit_s;
                                note_s    = key_note_s;
                                note_on_s = 1'b1;
                            end else begin
                                held_s = held_r;
                            end
                        end else if (scan_code == OCT_UP) begin
                            if (octave_r != OCT_MAX) begin
                                octave_s  = octave_r + 3'd1;
                                note_on_s = (note_r != 4'd0);
                            end else begin
                                octave_s = octave_r;
                            end
                        end else if (scan_code == OCT_DOWN) begin
                            if (octave_r != 3'd0) begin
                                octave_s  = octave_r - 3'd1;
                                note_on_s = (note_r != 4'd0);
                            end else begin
                                octave_s = octave_r;
                            end
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                end
                ST_BRK: begin
                    state_s = ST_IDLE;
                    if ((key_note_s != 4'd0) && ((held_r & key_bit_s) != 12'h000)) begin
                        held_s = remain_s;
                        if (key_note_s == note_r) begin
                            if (remain_s != 12'h000) begin
                                note_s    = highest_held(remain_s);
                                note_on_s = 1'b1;
                            end else begin
                                note_s     = 4'd0;
                                note_off_s = 1'b1;
                            end
                        end else begin
                            note_s = note_r;
                        end
                    end else begin
                        held_s = held_r;
                    end
                end
                ST_EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_s = ST_EXT_BRK;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_EXT_BRK: state_s = ST_IDLE;
                default:    state_s = ST_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            note_r       <= 4'd0;
            octave_r     <= OCT_RESET;
            held_r       <= 12'h000;
            note_valid_r <= 1'b0;
            note_on_r    <= 1'b0;
            note_off_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            note_r       <= note_s;
            octave_r     <= octave_s;
            held_r       <= held_s;
            note_valid_r <= (note_s != 4'd0);
            note_on_r    <= note_on_s;
            note_off_r   <= note_off_s;
        end
    end

    assign note       = note_r;
    assign octave     = octave_r;
    assign note_valid = note_valid_r;
    assign note_on    = note_on_r;
    assign note_off   = note_off_r;
    assign held_mask  = held_r;

endmodule
